// File: rtl/io_port.sv
// rtl/io_port.sv - write-back I/O port: one-entry OUT register, show-ahead IN FIFO, stall outputs
// Optional stall-event counter enabled by defining IO_PORT_ERR_CNT_EN.
module io_port #(
  parameter int DATA_W   = 16,
  parameter int IN_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              out_en,
  input  logic [DATA_W-1:0] out_wdata,
  output logic              out_stall,
  input  logic              in_en,
  output logic [DATA_W-1:0] in_rdata,
  output logic              in_stall,
  output logic [DATA_W-1:0] port_out_data,
  output logic              port_out_valid,
  input  logic              port_out_ready,
  input  logic [DATA_W-1:0] port_in_data,
  input  logic              port_in_valid,
  output logic              port_in_ready,
  input  logic              err_clr,
  output logic [7:0]        err_cnt
);

  localparam int PW = $clog2(IN_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(IN_DEPTH);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] mem_q [IN_DEPTH];
  logic [DATA_W-1:0] mem_d [IN_DEPTH];
  logic              out_load, push, pop;

  always_comb begin
    out_stall      = out_en & out_valid_q & ~port_out_ready;
    out_load       = out_en & ~out_stall;
    port_out_valid = out_valid_q;
    port_out_data  = out_data_q;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_load) begin
      out_valid_d = 1'b1;
      out_data_d  = out_wdata;
    end else if (out_valid_q & port_out_ready) begin
      out_valid_d = 1'b0;
    end

    // Ready comes only from the registered count, so a full FIFO refuses a push even during a pop.
    port_in_ready = (count_q != FULL);
    push          = port_in_valid & port_in_ready;
    pop           = in_en & (count_q != '0);
    in_stall      = in_en & (count_q == '0);
    in_rdata      = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = port_in_data;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < IN_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_q       <= mem_d;
    end
  end

`ifdef IO_PORT_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) err_cnt_d = '0;
    else if ((out_stall | in_stall) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    err_cnt = err_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule
